rgb2hsv: RTL and testbench



---
 rtl/rgb2hsv_pkg.sv | 38 +++
 rtl/rgb2hsv_serial_divider.sv | 66 ++++++
 rtl/rgb2hsv.sv | 158 +++++++++++++++
 tb/tb_rgb2hsv.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/rgb2hsv_pkg.sv
// Shared definitions for the RGB->HSV converter: packing offsets, hue sector
// bases, divider sizing and the controller state type.
package rgb2hsv_pkg;

   // Pixel packing: RGB arrives as {R,B,G}, HSV leaves as {H,S,V}
   localparam int R_LSB = 16;
   localparam int B_LSB = 8;
   localparam int G_LSB = 0;
   localparam int H_LSB = 16;
   localparam int S_LSB = 8;
   localparam int V_LSB = 0;

   localparam logic [2:0] SECT_R    = 3'd0;
   localparam logic [2:0] SECT_G    = 3'd2;
   localparam logic [2:0] SECT_B    = 3'd4;
   localparam logic [2:0] SECT_WRAP = 3'd6;

   localparam int HUE_SCALE = 256;
   localparam int HUE_SHIFT = 8;

   localparam int DIV_W = 19;   // widest dividend: N*256
   localparam int DVS_W = 11;   // widest divisor: 6*delta
   localparam int CNT_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MINMAX,
      ST_DIV_S,
      ST_DIV_H,
      ST_DONE
   } state_t;

   function automatic logic [DVS_W-1:0] scale_delta(input logic [2:0] k,
                                                    input logic [7:0] d);
      return DVS_W'(k) * DVS_W'(d);
   endfunction

endpackage

// File: rtl/rgb2hsv_serial_divider.sv
// Restoring divider, one quotient bit per clock. The dividend is consumed MSB
// first, so shorter dividends are loaded left-aligned with a smaller i_iter.
module serial_divider
   import rgb2hsv_pkg::*;
#(
   parameter int WIDTH = DIV_W,
   parameter int DW    = DVS_W,
   parameter int QW    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [DW-1:0]    i_divisor,
   input  logic [CNT_W-1:0] i_iter,
   output logic             o_busy,
   output logic             o_done,
   output logic [QW-1:0]    o_quotient
);

   logic [WIDTH-1:0] r_dvd;
   logic [DW-1:0]    r_div;
   logic [DW-1:0]    r_rem;
   logic [QW-1:0]    r_q;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;

   logic [DW:0]      w_trial;
   logic             w_ge;
   logic [DW-1:0]    w_rem_next;

   assign w_trial    = {r_rem, r_dvd[WIDTH-1]};
   assign w_ge       = (w_trial >= {1'b0, r_div});
   assign w_rem_next = DW'(w_ge ? (w_trial - {1'b0, r_div}) : w_trial);

   // Quotient including the bit decided this cycle; complete while o_done is high
   assign o_quotient = {r_q[QW-2:0], w_ge};
   assign o_done     = r_busy && (r_cnt == '0);
   assign o_busy     = r_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dvd  <= '0;
         r_div  <= '0;
         r_rem  <= '0;
         r_q    <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_dvd  <= i_dividend;
         r_div  <= i_divisor;
         r_rem  <= '0;
         r_q    <= '0;
         r_cnt  <= i_iter - CNT_W'(1);
         r_busy <= (i_iter != '0);
      end else if (r_busy) begin
         r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
         r_rem  <= w_rem_next;
         r_q    <= {r_q[QW-2:0], w_ge};
         r_cnt  <= r_cnt - CNT_W'(1);
         if (r_cnt == '0)
            r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/rgb2hsv.sv
// Packed RGB to packed HSV converter with fixed latency; one shared serial
// divider computes saturation then hue for a single pixel in flight.
module rgb2hsv
   import rgb2hsv_pkg::*;
#(
   parameter int H_ITER = 19,
   parameter int S_ITER = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] tRGB,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [23:0] tHSV,
   output logic        out_valid,
   input  logic        out_ready
);

   state_t            r_state;
   state_t            w_state_next;
   logic [23:0]       r_rgb;
   logic [7:0]        r_max;
   logic [7:0]        r_delta;
   logic [DVS_W-1:0]  r_n;
   logic [7:0]        r_s;
   logic [7:0]        r_h;
   logic [23:0]       r_thsv;
   logic              r_out_valid;

   logic [7:0]        w_r, w_g, w_b;
   logic [7:0]        w_max, w_min, w_delta;
   logic [2:0]        w_base;
   logic [DVS_W-1:0]  w_diff, w_n;
   logic [15:0]       w_s_prod;

   logic              w_div_start;
   logic [DIV_W-1:0]  w_div_dividend;
   logic [DVS_W-1:0]  w_div_divisor;
   logic [CNT_W-1:0]  w_div_iter;
   logic              w_div_busy;
   logic              w_div_done;
   logic [7:0]        w_div_q;

   assign w_r = r_rgb[R_LSB +: 8];
   assign w_g = r_rgb[G_LSB +: 8];
   assign w_b = r_rgb[B_LSB +: 8];

   // Max selection with tie priority R > G > B; the signed channel difference
   // is kept modulo 2^11 so base*delta + diff lands on the unsigned numerator.
   always_comb begin
      w_max  = w_b;
      w_base = SECT_B;
      w_diff = DVS_W'(w_r) - DVS_W'(w_g);
      if (w_r >= w_g && w_r >= w_b) begin
         w_max  = w_r;
         w_base = (w_g >= w_b) ? SECT_R : SECT_WRAP;
         w_diff = DVS_W'(w_g) - DVS_W'(w_b);
      end else if (w_g >= w_b) begin
         w_max  = w_g;
         w_base = SECT_G;
         w_diff = DVS_W'(w_b) - DVS_W'(w_r);
      end
   end

   assign w_min    = (w_r <= w_g && w_r <= w_b) ? w_r : ((w_g <= w_b) ? w_g : w_b);
   assign w_delta  = w_max - w_min;
   assign w_n      = scale_delta(w_base, w_delta) + w_diff;
   assign w_s_prod = 16'(w_delta) * 16'(8'd255);

   always_comb begin
      w_state_next   = r_state;
      w_div_start    = 1'b0;
      w_div_dividend = '0;
      w_div_divisor  = '0;
      w_div_iter     = '0;
      case (r_state)
         ST_IDLE:   if (in_valid) w_state_next = ST_MINMAX;
         ST_MINMAX: begin
            w_div_start    = 1'b1;
            w_div_dividend = DIV_W'(w_s_prod) << (DIV_W - S_ITER);
            w_div_divisor  = DVS_W'(w_max);
            w_div_iter     = CNT_W'(S_ITER);
            w_state_next   = ST_DIV_S;
         end
         ST_DIV_S: begin
            if (w_div_done) begin
               w_div_start    = 1'b1;
               w_div_dividend = {r_n, {HUE_SHIFT{1'b0}}};
               w_div_divisor  = scale_delta(SECT_WRAP, r_delta);
               w_div_iter     = CNT_W'(H_ITER);
               w_state_next   = ST_DIV_H;
            end
         end
         ST_DIV_H:  if (w_div_done) w_state_next = ST_DONE;
         ST_DONE:   if (r_out_valid && out_ready) w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_rgb       <= '0;
         r_max       <= '0;
         r_delta     <= '0;
         r_n         <= '0;
         r_s         <= '0;
         r_h         <= '0;
         r_thsv      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ST_IDLE:   if (in_valid) r_rgb <= tRGB;
            ST_MINMAX: begin
               r_max   <= w_max;
               r_delta <= w_delta;
               r_n     <= w_n;
            end
            // Degenerate pixels still run both divides; the zero rules win here
            ST_DIV_S:  if (w_div_done) r_s <= (r_max == '0) ? 8'd0 : w_div_q;
            ST_DIV_H:  if (w_div_done) r_h <= (r_delta == '0) ? 8'd0 : w_div_q;
            ST_DONE: begin
               if (!r_out_valid) begin
                  r_thsv[H_LSB +: 8] <= r_h;
                  r_thsv[S_LSB +: 8] <= r_s;
                  r_thsv[V_LSB +: 8] <= r_max;
                  r_out_valid        <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   serial_divider #(
      .WIDTH (DIV_W),
      .DW    (DVS_W),
      .QW    (8)
   ) u_div (
      .clk        (clk),
      .reset      (reset),
      .i_start    (w_div_start),
      .i_dividend (w_div_dividend),
      .i_divisor  (w_div_divisor),
      .i_iter     (w_div_iter),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done),
      .o_quotient (w_div_q)
   );

   assign in_ready  = (r_state == ST_IDLE) && !w_div_busy;
   assign tHSV      = r_thsv;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rgb2hsv.sv
// Directed and randomised checks of rgb2hsv against an integer HSV model,
// including latency, backpressure and mid-conversion reset.
module tb_rgb2hsv;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] tRGB;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] tHSV;
   logic        out_valid;
   logic        out_ready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rgb2hsv dut (
      .clk       (clk),
      .reset     (reset),
      .tRGB      (tRGB),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tHSV      (tHSV),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Golden HSV from plain integer arithmetic; input packed {R,B,G}
   function automatic logic [23:0] ref_hsv(input logic [23:0] p);
      int r, g, b, mx, mn, d, n, h, s;
      r  = int'(p[23:16]);
      b  = int'(p[15:8]);
      g  = int'(p[7:0]);
      mx = (r > g) ? r : g;
      mx = (mx > b) ? mx : b;
      mn = (r < g) ? r : g;
      mn = (mn < b) ? mn : b;
      d  = mx - mn;
      if (r == mx)      n = (g >= b) ? (g - b) : (6 * d + g - b);
      else if (g == mx) n = 2 * d + b - r;
      else              n = 4 * d + r - g;
      s = (mx == 0) ? 0 : (d * 255) / mx;
      h = (d == 0) ? 0 : (n * 256) / (6 * d);
      return {8'(h), 8'(s), 8'(mx)};
   endfunction

   // One pixel through the block; stall = cycles out_ready is held low after out_valid
   task automatic convert(input logic [23:0] px, input logic [23:0] exp,
                          input int stall, input string tag);
      int waitc;
      int lat;
      out_ready = (stall == 0);
      tRGB      = px;
      in_valid  = 1'b1;
      waitc     = 0;
      while (!in_ready && waitc < 100) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      tRGB     = 24'($urandom);
      lat      = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'd37);
      chk({tag, " tHSV"}, 32'(tHSV), 32'(exp));
      for (int i = 0; i < stall; i++) begin
         tRGB     = 24'($urandom);
         in_valid = 1'($urandom);
         @(posedge clk); #1;
         if (stall >= 10) begin
            chk({tag, " hold tHSV"}, 32'(tHSV), 32'(exp));
            chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
   endtask

   logic [23:0] dir_px  [7] = '{24'hFF0000, 24'h0000FF, 24'h00FF00, 24'h808080,
                                24'h000000, 24'hC83264, 24'hFF8000};
   logic [23:0] dir_exp [7] = '{24'h00FFFF, 24'h55FFFF, 24'hAAFFFF, 24'h000080,
                                24'h000000, 24'h0EBFC8, 24'hEAFFFF};

   initial begin
      logic [23:0] px;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tRGB      = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset tHSV", 32'(tHSV), 32'd0);

      for (int i = 0; i < 7; i++) begin
         convert(dir_px[i], dir_exp[i], 0, $sformatf("dir%0d", i));
         $display("dir%0d rgb=%06h hsv=%06h", i, dir_px[i], tHSV);
      end

      convert(24'hC83264, 24'h0EBFC8, 10, "backpressure");
      $display("backpressure rgb=C83264 hsv=%06h", tHSV);

      tRGB      = 24'hFF0000;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midreset out_valid", 32'(out_valid), 32'd0);
      chk("midreset in_ready", 32'(in_ready), 32'd1);
      chk("midreset tHSV", 32'(tHSV), 32'd0);
      convert(24'hFF8000, 24'hEAFFFF, 0, "after_reset");
      $display("after_reset rgb=FF8000 hsv=%06h", tHSV);

      for (int i = 0; i < 1000; i++) begin
         px = 24'($urandom);
         convert(px, ref_hsv(px), int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
         $display("rand%0d rgb=%06h hsv=%06h", i, px, tHSV);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
